// File: rtl/switch_debounce_pkg.sv
// Shared defaults and helpers for the switch debounce array.
// Holds the channel counter-width function used by every channel instance.
package switch_debounce_pkg;

  localparam int unsigned BIT_COUNT_DEFAULT       = 16;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

  typedef enum logic {
    MODE_LEVEL  = 1'b0,
    MODE_TOGGLE = 1'b1
  } chan_mode_e;

  // Counter must hold 0..DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_array_channel.sv
// Single switch channel: 2-flop synchronizer, stability counter, level/toggle
// output stage and registered rise/fall pulses.
module debounce_channel
  import switch_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit          INVERT          = 1'b1,
  parameter bit          TOGGLE          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic led,
  output logic rise,
  output logic fall
);

  localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam chan_mode_e     MODE     = chan_mode_e'(TOGGLE);

  logic          s1;
  logic          s2;
  logic          st;
  logic          tg;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          st_next;
  logic          tg_next;
  logic          value_next;
  logic [CW-1:0] cnt_next;

  always_comb begin
    accept     = 1'b0;
    cnt_next   = '0;
    st_next    = st;
    tg_next    = tg;
    value_next = 1'b0;
    if (s2 != st) begin
      if (cnt == CNT_LAST) begin
        accept = 1'b1;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
    if (accept) begin
      st_next = s2;
      if (s2) begin
        tg_next = ~tg;
      end
    end
    // led is computed from next-state so it lands on the same edge as st.
    value_next = (MODE == MODE_TOGGLE) ? tg_next : st_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      st   <= 1'b0;
      tg   <= 1'b0;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
      led  <= INVERT;
    end else begin
      s1   <= sw;
      s2   <= s1;
      st   <= st_next;
      tg   <= tg_next;
      cnt  <= cnt_next;
      rise <= accept & s2;
      fall <= accept & ~s2;
      led  <= value_next ^ INVERT;
    end
  end

endmodule

// File: rtl/switch_debounce_array.sv
// Array of independent debounced switch channels driving LEDs, with per-channel
// level/toggle mode selected by TOGGLE_MASK.
module switch_debounce_array
  import switch_debounce_pkg::*;
#(
  parameter int unsigned           BIT_COUNT       = BIT_COUNT_DEFAULT,
  parameter int unsigned           DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit                    INVERT          = 1'b1,
  parameter logic [BIT_COUNT-1:0]  TOGGLE_MASK     = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_COUNT-1:0] sw,
  output logic [BIT_COUNT-1:0] led,
  output logic [BIT_COUNT-1:0] rise,
  output logic [BIT_COUNT-1:0] fall
);

  for (genvar i = 0; i < BIT_COUNT; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (INVERT),
      .TOGGLE          (TOGGLE_MASK[i])
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (sw[i]),
      .led   (led[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule

// File: tb/tb_switch_debounce_array.sv
// Directed bench for switch_debounce_array: 16 channels, 4-cycle debounce,
// inverted LEDs, channel 5 in toggle mode.
module tb_switch_debounce_array;

  logic        clk;
  logic        rst_n;
  logic [15:0] sw;
  logic [15:0] led;
  logic [15:0] rise;
  logic [15:0] fall;

  int passed = 0;
  int total  = 0;

  switch_debounce_array #(
    .BIT_COUNT       (16),
    .DEBOUNCE_CYCLES (4),
    .INVERT          (1'b1),
    .TOGGLE_MASK     (16'h0020)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .led   (led),
    .rise  (rise),
    .fall  (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic check_quiet(input string tag, input logic [15:0] exp_led);
    check({tag, "_led"}, led, exp_led);
    check({tag, "_rise"}, rise, 16'h0000);
    check({tag, "_fall"}, fall, 16'h0000);
  endtask

  initial begin
    logic [15:0] exp_led;
    int rise5;
    int fall5;

    // Reset with all switches on
    rst_n = 1'b0;
    sw    = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet("reset_hold", 16'hFFFF);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_quiet("reset_wait", 16'hFFFF);
    end
    step();
    check("reset_accept_led", led, 16'h0000);
    check("reset_accept_rise", rise, 16'hFFFF);
    check("reset_accept_fall", fall, 16'h0000);
    step();
    check_quiet("reset_after", 16'h0000);

    // All switches off: level channels relight, toggle channel 5 keeps tg=1
    sw = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      step();
      check_quiet("settle_wait", 16'h0000);
    end
    step();
    check("settle_led", led, 16'hFFDF);
    check("settle_fall", fall, 16'hFFFF);
    check("settle_rise", rise, 16'h0000);
    step();
    check_quiet("settle_after", 16'hFFDF);

    // Clean step on sw[0]
    sw = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      step();
      check_quiet("step_wait", 16'hFFDF);
    end
    step();
    check("step_led", led, 16'hFFDE);
    check("step_rise", rise, 16'h0001);
    check("step_fall", fall, 16'h0000);
    step();
    check_quiet("step_after", 16'hFFDE);

    // Glitches on sw[3]: 3-cycle high, then 1-cycle alternation
    sw = 16'h0009;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet("glitch3", 16'hFFDE);
    end
    for (int i = 0; i < 20; i++) begin
      sw = (i % 2 == 1) ? 16'h0009 : 16'h0001;
      step();
      check_quiet("glitch_alt", 16'hFFDE);
    end
    sw = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      step();
      check_quiet("glitch_tail", 16'hFFDE);
    end

    // Fresh reset so toggle channel starts from tg=0
    rst_n = 1'b0;
    step();
    step();
    check_quiet("rst2_hold", 16'hFFFF);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_quiet("rst2_wait", 16'hFFFF);
    end
    step();
    check("rst2_led", led, 16'hFFFE);
    check("rst2_rise", rise, 16'h0001);
    step();

    // Toggle channel 5: two presses, 10 cycles high / 10 low each
    exp_led = 16'hFFFE;
    rise5   = 0;
    fall5   = 0;
    for (int p = 0; p < 4; p++) begin
      sw = (p % 2 == 0) ? 16'h0021 : 16'h0001;
      for (int j = 1; j <= 10; j++) begin
        step();
        if (rise[5]) rise5++;
        if (fall[5]) fall5++;
        if (j == 6 && p % 2 == 0) exp_led = exp_led ^ 16'h0020;
        check("toggle_led", led, exp_led);
        if (j == 6) begin
          check("toggle_rise", rise, (p % 2 == 0) ? 16'h0020 : 16'h0000);
          check("toggle_fall", fall, (p % 2 == 0) ? 16'h0000 : 16'h0020);
        end
      end
    end
    check("toggle_rise_count", 16'(rise5), 16'd2);
    check("toggle_fall_count", 16'(fall5), 16'd2);

    // Simultaneous change on several channels
    sw = 16'hA5A5;
    for (int i = 0; i < 5; i++) begin
      step();
      check_quiet("simul_wait", 16'hFFFE);
    end
    step();
    check("simul_led", led, 16'h5A5A);
    check("simul_rise", rise, 16'hA5A4);
    check("simul_fall", fall, 16'h0000);
    step();
    check_quiet("simul_after", 16'h5A5A);

    // Reset while counting towards all-off
    sw = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      step();
      check_quiet("midrst_count", 16'h5A5A);
    end
    rst_n = 1'b0;
    step();
    check_quiet("midrst_hold", 16'hFFFF);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_quiet("midrst_after", 16'hFFFF);
    end

    // Reset while counting towards all-on: full latency required afterwards
    sw = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      step();
      check_quiet("midrst2_count", 16'hFFFF);
    end
    rst_n = 1'b0;
    step();
    check_quiet("midrst2_hold", 16'hFFFF);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_quiet("midrst2_wait", 16'hFFFF);
    end
    step();
    check("midrst2_led", led, 16'h0000);
    check("midrst2_rise", rise, 16'hFFFF);
    check("midrst2_fall", fall, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
